// File: rtl/qs_srt_pkg.sv
// rtl/qs_srt_pkg.sv - shared qs_srt types: registers, microcode word, issue FSM states
package qs_srt_pkg;

  localparam int QS_SRT_REGS_N     = 8;
  localparam int QS_SRT_LD_OUTST_N = 4;

  typedef logic [2:0] reg_t;
  localparam reg_t BLINK = 3'd7;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_LD    = 4'd2,
    OP_POP   = 4'd3,
    OP_JCC   = 4'd4,
    OP_CALL  = 4'd5,
    OP_RET   = 4'd6,
    OP_AWAIT = 4'd7,
    OP_ILL   = 4'd15
  } opcode_t;

  typedef struct packed {
    opcode_t     op;
    reg_t        dst;
    reg_t        src0;
    reg_t        src1;
    logic        dst_en;
    logic        src0_en;
    logic        src1_en;
    logic        is_load;
    logic        is_pop;
    logic        is_jump;
    logic        is_ret;
    logic        is_await;
    logic        invalid_inst;
    logic [15:0] imm;
  } ucode_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    AWAIT   = 2'd2,
    ERROR   = 2'd3
  } issue_state_t;

  function automatic logic is_ctrl(input ucode_t u);
    return u.is_jump | u.is_ret;
  endfunction

  function automatic logic uses_credit(input ucode_t u);
    return u.is_load | u.is_pop;
  endfunction

endpackage

// File: rtl/qs_srt_scoreboard.sv
// rtl/qs_srt_scoreboard.sv - pending-writeback register vector and outstanding LD/POP credit counter
module qs_srt_scoreboard
  import qs_srt_pkg::*;
#(
  parameter int REGS_N  = QS_SRT_REGS_N,
  parameter int OUTST_N = QS_SRT_LD_OUTST_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_vld,
  input  reg_t              set_idx,
  input  logic              clr_vld,
  input  reg_t              clr_idx,
  output logic [REGS_N-1:0] sb,
  output logic              full,
  output logic              empty,
  output logic              clr_err
);

  localparam int CW = $clog2(OUTST_N + 1);

  logic [CW-1:0]     cnt;
  logic [REGS_N-1:0] sb_nxt;
  logic              clr_ok;

  // A writeback for a register nobody is waiting on is dropped so cnt never underflows.
  assign clr_err = clr_vld & ((cnt == '0) | ~sb[clr_idx]);
  assign clr_ok  = clr_vld & ~clr_err;
  assign full    = (cnt == CW'(OUTST_N));
  assign empty   = (cnt == '0);

  always_comb begin
    sb_nxt = sb;
    if (clr_ok)  sb_nxt[clr_idx] = 1'b0;
    if (set_vld) sb_nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb  <= '0;
      cnt <= '0;
    end else begin
      sb <= sb_nxt;
      case ({set_vld, clr_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/qs_srt_issue_ctrl.sv
// rtl/qs_srt_issue_ctrl.sv - issue controller: hazard/credit gating, control-flow FSM, registered issue slot
module qs_srt_issue_ctrl
  import qs_srt_pkg::*;
#(
  parameter int REGS_N     = QS_SRT_REGS_N,
  parameter int LD_OUTST_N = QS_SRT_LD_OUTST_N
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   dec_vld,
  input  ucode_t dec_ucode,
  output logic   dec_rdy,
  output logic   iss_vld,
  output ucode_t iss_ucode,
  input  logic   iss_rdy,
  input  logic   wb_vld,
  input  reg_t   wb_dst,
  input  logic   br_done,
  input  logic   evt_vld,
  output logic   fe_flush,
  output logic   busy,
  output logic   err
);

  issue_state_t      state, state_nxt;
  logic [REGS_N-1:0] sb;
  logic              sb_full, sb_empty, wb_err;
  logic              hz, credit_stall, slot_free, ill_seen;

  qs_srt_scoreboard #(
    .REGS_N (REGS_N),
    .OUTST_N(LD_OUTST_N)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_vld(dec_rdy & uses_credit(dec_ucode)),
    .set_idx(dec_ucode.dst),
    .clr_vld(wb_vld),
    .clr_idx(wb_dst),
    .sb     (sb),
    .full   (sb_full),
    .empty  (sb_empty),
    .clr_err(wb_err)
  );

  // Hazard looks only at the registered scoreboard; a same-cycle writeback is not bypassed.
  assign hz = (dec_ucode.src0_en & sb[dec_ucode.src0])
            | (dec_ucode.src1_en & sb[dec_ucode.src1])
            | (dec_ucode.dst_en  & sb[dec_ucode.dst]);

  assign credit_stall = uses_credit(dec_ucode) & sb_full;
  assign slot_free    = ~iss_vld | iss_rdy;
  assign ill_seen     = (state == RUN) & dec_vld & dec_ucode.invalid_inst;

  assign dec_rdy = (state == RUN) & dec_vld & ~dec_ucode.invalid_inst
                 & ~hz & ~credit_stall & slot_free;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ill_seen)                              state_nxt = ERROR;
        else if (dec_rdy && is_ctrl(dec_ucode))    state_nxt = BR_WAIT;
        else if (dec_rdy && dec_ucode.is_await)    state_nxt = AWAIT;
      end
      BR_WAIT: if (br_done) state_nxt = RUN;
      AWAIT:   if (evt_vld) state_nxt = RUN;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      iss_vld   <= 1'b0;
      iss_ucode <= '0;
      fe_flush  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_nxt;
      fe_flush <= dec_rdy & is_ctrl(dec_ucode);
      err      <= err | ill_seen | wb_err;
      if (dec_rdy) begin
        iss_vld   <= 1'b1;
        iss_ucode <= dec_ucode;
      end else if (iss_rdy) begin
        iss_vld   <= 1'b0;
      end
    end
  end

  assign busy = (state != RUN) | ~sb_empty;

endmodule

// File: tb/tb_qs_srt_issue_ctrl.sv
// tb/tb_qs_srt_issue_ctrl.sv - directed self-checking bench for qs_srt_issue_ctrl with issue scoreboard
module tb_qs_srt_issue_ctrl;
  import qs_srt_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   dec_vld = 1'b0;
  ucode_t dec_ucode = '0;
  logic   dec_rdy;
  logic   iss_vld;
  ucode_t iss_ucode;
  logic   iss_rdy = 1'b1;
  logic   wb_vld = 1'b0;
  reg_t   wb_dst = '0;
  logic   br_done = 1'b0;
  logic   evt_vld = 1'b0;
  logic   fe_flush, busy, err;

  int     n_total = 0;
  int     n_pass = 0;
  logic   last_rdy;
  ucode_t exp_q[$];
  ucode_t exp_u, u_a, u_b;

  qs_srt_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dec_vld(dec_vld), .dec_ucode(dec_ucode), .dec_rdy(dec_rdy),
    .iss_vld(iss_vld), .iss_ucode(iss_ucode), .iss_rdy(iss_rdy), .wb_vld(wb_vld),
    .wb_dst(wb_dst), .br_done(br_done), .evt_vld(evt_vld), .fe_flush(fe_flush),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic ucode_t mk(input opcode_t op, input reg_t d, input reg_t s0, input reg_t s1,
                                input logic de, input logic s0e, input logic s1e);
    ucode_t u;
    u = '0;
    u.op = op; u.dst = d; u.src0 = s0; u.src1 = s1;
    u.dst_en = de; u.src0_en = s0e; u.src1_en = s1e;
    u.is_load      = (op == OP_LD);
    u.is_pop       = (op == OP_POP);
    u.is_jump      = (op == OP_JCC) || (op == OP_CALL);
    u.is_ret       = (op == OP_RET);
    u.is_await     = (op == OP_AWAIT);
    u.invalid_inst = (op == OP_ILL);
    u.imm = 16'($urandom_range(0, 16'hffff));
    return u;
  endfunction

  // Sample mid-cycle: record acceptance, retire issued slots against the queue, then advance one edge.
  task automatic step();
    #1;
    last_rdy = dec_rdy;
    if (dec_rdy) exp_q.push_back(dec_ucode);
    if (iss_vld && iss_rdy) begin
      if (exp_q.size() == 0) chk("iss_unexpected", 64'(iss_ucode), 64'd0 - 64'd1);
      else begin
        exp_u = exp_q.pop_front();
        chk("iss_ucode", 64'(iss_ucode), 64'(exp_u));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(input ucode_t u);
    dec_vld = 1'b1;
    dec_ucode = u;
  endtask

  task automatic idle();
    dec_vld = 1'b0;
    dec_ucode = '0;
  endtask

  task automatic wb(input reg_t r);
    wb_vld = 1'b1; wb_dst = r;
    step();
    wb_vld = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_iss_vld", 64'(iss_vld), 64'd0);
    chk("rst_fe_flush", 64'(fe_flush), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_dec_rdy", 64'(last_rdy), 64'd0);

    // 1: ADD accepted same cycle, issued next cycle; held while iss_rdy=0
    u_a = mk(OP_ADD, 3'd1, 3'd2, 3'd3, 1, 1, 1);
    present(u_a); step();
    chk("t1_dec_rdy", 64'(last_rdy), 64'd1);
    chk("t1_iss_vld", 64'(iss_vld), 64'd1);
    chk("t1_iss_ucode", 64'(iss_ucode), 64'(u_a));
    chk("t1_busy", 64'(busy), 64'd0);
    iss_rdy = 1'b0;
    u_b = mk(OP_ADD, 3'd5, 3'd6, 3'd7, 1, 1, 1);
    present(u_b); step();
    chk("t1_hold_rdy", 64'(last_rdy), 64'd0);
    chk("t1_hold_ucode", 64'(iss_ucode), 64'(u_a));
    iss_rdy = 1'b1; step();
    chk("t1_slot_free_rdy", 64'(last_rdy), 64'd1);
    idle(); step();
    chk("t1_drain_vld", 64'(iss_vld), 64'd0);

    // 2: RAW hazard on a pending load, no same-cycle bypass
    present(mk(OP_LD, 3'd2, 3'd0, 3'd0, 1, 0, 0)); step();
    chk("t2_ld_rdy", 64'(last_rdy), 64'd1);
    chk("t2_busy", 64'(busy), 64'd1);
    present(mk(OP_ADD, 3'd4, 3'd2, 3'd3, 1, 1, 1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hz_rdy", 64'(last_rdy), 64'd0);
    end
    wb(3'd2);
    chk("t2_wb_cycle_rdy", 64'(last_rdy), 64'd0);
    step();
    chk("t2_after_wb_rdy", 64'(last_rdy), 64'd1);
    idle(); step();
    chk("t2_busy_clear", 64'(busy), 64'd0);

    // 3: credit limit of four outstanding loads
    for (int r = 1; r <= 4; r++) begin
      present(mk(OP_LD, reg_t'(r), 3'd0, 3'd0, 1, 0, 0)); step();
      chk("t3_ld_rdy", 64'(last_rdy), 64'd1);
    end
    present(mk(OP_LD, 3'd5, 3'd0, 3'd0, 1, 0, 0));
    step();
    chk("t3_credit_rdy", 64'(last_rdy), 64'd0);
    wb(3'd1);
    chk("t3_credit_wb_rdy", 64'(last_rdy), 64'd0);
    step();
    chk("t3_fifth_rdy", 64'(last_rdy), 64'd1);
    idle();
    for (int r = 2; r <= 5; r++) wb(reg_t'(r));
    chk("t3_drained_busy", 64'(busy), 64'd0);
    chk("t3_err", 64'(err), 64'd0);

    // 4: JCC flushes fetch once and blocks until br_done
    present(mk(OP_JCC, 3'd0, 3'd1, 3'd0, 0, 1, 0)); step();
    chk("t4_jcc_rdy", 64'(last_rdy), 64'd1);
    chk("t4_flush", 64'(fe_flush), 64'd1);
    chk("t4_iss_vld", 64'(iss_vld), 64'd1);
    present(mk(OP_ADD, 3'd1, 3'd2, 3'd3, 1, 1, 1)); step();
    chk("t4_flush_pulse", 64'(fe_flush), 64'd0);
    chk("t4_wait_rdy", 64'(last_rdy), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    evt_vld = 1'b1; step(); evt_vld = 1'b0;
    chk("t4_evt_ignored", 64'(last_rdy), 64'd0);
    br_done = 1'b1; step(); br_done = 1'b0;
    chk("t4_br_cycle_rdy", 64'(last_rdy), 64'd0);
    step();
    chk("t4_resume_rdy", 64'(last_rdy), 64'd1);
    idle(); step();

    // 5: AWAIT blocks until evt_vld
    present(mk(OP_AWAIT, 3'd0, 3'd0, 3'd0, 0, 0, 0)); step();
    chk("t5_await_rdy", 64'(last_rdy), 64'd1);
    present(mk(OP_ADD, 3'd2, 3'd3, 3'd4, 1, 1, 1));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_wait_rdy", 64'(last_rdy), 64'd0);
    end
    evt_vld = 1'b1; step(); evt_vld = 1'b0;
    chk("t5_evt_cycle_rdy", 64'(last_rdy), 64'd0);
    step();
    chk("t5_resume_rdy", 64'(last_rdy), 64'd1);
    idle(); step();
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // 6: illegal instruction traps; reset clears; stray wb flags error
    present(mk(OP_ILL, 3'd1, 3'd0, 3'd0, 1, 0, 0)); step();
    chk("t6_ill_rdy", 64'(last_rdy), 64'd0);
    chk("t6_err", 64'(err), 64'd1);
    chk("t6_busy", 64'(busy), 64'd1);
    present(mk(OP_ADD, 3'd1, 3'd2, 3'd3, 1, 1, 1)); step();
    chk("t6_error_rdy", 64'(last_rdy), 64'd0);
    chk("t6_no_issue", 64'(iss_vld), 64'd0);
    idle();
    rst_n = 1'b0; #1;
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    wb(3'd3);
    chk("t6_wb_err", 64'(err), 64'd1);
    chk("t6_wb_busy", 64'(busy), 64'd0);
    present(mk(OP_ADD, 3'd1, 3'd2, 3'd3, 1, 1, 1)); step();
    chk("t6_still_run_rdy", 64'(last_rdy), 64'd1);
    idle(); step();
    chk("t6_err_sticky", 64'(err), 64'd1);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
